// File: rtl/cacheline_mem_arbiter.sv
// Cacheline memory arbiter: shares one burst memory port between icache and dcache.
// Round-robin line grants, BEATS-beat bursts per line, one-cycle resp pulse per line.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_read/i_addr/i_rdata/i_resp     icache line read channel
//   d_read/d_write/d_addr/d_wdata/   dcache line read/writeback channel
//   d_rdata/d_resp
//   mem_read/mem_write/mem_addr/     burst memory port, one mem_resp strobe per beat
//   mem_burst_o/mem_burst_i/mem_resp
module cacheline_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BURST_W-1:0] mem_burst_o,
    input  logic [BURST_W-1:0] mem_burst_i,
    input  logic               mem_resp
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Clears the byte-offset-within-line bits.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic              last_d;
    logic              owner_d;
    logic [LINE_W-1:0] line;

    logic req_i;
    logic req_d;
    logic grant_i;
    logic last_beat;

    assign req_i     = i_read;
    assign req_d     = d_read | d_write;
    // On a tie the side that did not win last time gets the port.
    assign grant_i   = req_i & (~req_d | last_d);
    assign last_beat = (beat == BW'(BEATS - 1));

    assign mem_burst_o = (state == D_WR) ? d_wdata[beat*BURST_W +: BURST_W] : '0;
    assign i_rdata     = i_resp ? line : '0;
    assign d_rdata     = d_resp ? line : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            line      <= '0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state    <= I_RD;
                        owner_d  <= 1'b0;
                        last_d   <= 1'b0;
                        mem_read <= 1'b1;
                        mem_addr <= i_addr & LINE_MASK;
                    end else if (req_d) begin
                        owner_d  <= 1'b1;
                        last_d   <= 1'b1;
                        mem_addr <= d_addr & LINE_MASK;
                        // A simultaneous read+write is treated as a writeback.
                        if (d_write) begin
                            state     <= D_WR;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= D_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (mem_resp) begin
                        if (state != D_WR) begin
                            line[beat*BURST_W +: BURST_W] <= mem_burst_i;
                        end
                        if (last_beat) begin
                            state     <= DONE;
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            mem_addr  <= '0;
                            i_resp    <= ~owner_d;
                            d_resp    <= owner_d;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    beat   <= '0;
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Testbench for cacheline_mem_arbiter: directed scenarios plus randomized traffic
// checked against a word-addressed memory model and a round-robin grant model.
module tb_cacheline_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_burst_o;
    logic [63:0]  mem_burst_i;
    logic         mem_resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_resp = 0;
    bit last_d_m;

    logic [63:0] mem_model [logic [31:0]];

    cacheline_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_burst_o (mem_burst_o),
        .mem_burst_i (mem_burst_i),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd_word(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = {$urandom, $urandom};
        return mem_model[a];
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Round-robin reference: icache first after reset, then alternate on ties.
    function automatic bit pick_d(input bit ri, input bit rd);
        bit od;
        if (ri && rd) od = !last_d_m;
        else od = rd;
        last_d_m = od;
        return od;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        mem_resp = 0; mem_burst_i = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_d_m = 1'b1;
    endtask

    // Memory side: waits for a command, then serves four beats with an
    // optional stall of st cycles in front of beat sb.
    task automatic serve(input string tag, input bit wr, input logic [31:0] base,
                         input logic [255:0] wl, input int sb, input int st,
                         output bit ok);
        int n = 0;
        ok = 0;
        while (!(mem_read || mem_write) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check({tag, "_cmd_timeout"}, 0, 1);
            return;
        end
        check({tag, "_mem_write"}, mem_write, wr);
        check({tag, "_mem_read"}, mem_read, !wr);
        check({tag, "_mem_addr"}, mem_addr, base);
        for (int k = 0; k < 4; k++) begin
            if (k == sb && st > 0) begin
                mem_resp = 0;
                repeat (st) @(negedge clk);
                check({tag, "_stall_resp"}, {i_resp, d_resp}, 0);
                check({tag, "_stall_cmd"}, {mem_read, mem_write}, {!wr, wr});
            end
            mem_resp = 1;
            if (wr) begin
                check({tag, "_wbeat"}, mem_burst_o, wl[64*k +: 64]);
                mem_model[base + 32'(8*k)] = wl[64*k +: 64];
            end else begin
                mem_burst_i = rd_word(base + 32'(8*k));
            end
            @(negedge clk);
        end
        mem_resp = 0;
        mem_burst_i = 0;
        ok = 1;
    endtask

    task automatic run_one(input string tag, input bit od, input bit wr,
                           input logic [31:0] base, input logic [255:0] wl,
                           input int sb, input int st, input bit keep);
        bit ok;
        logic [255:0] exp;
        serve(tag, wr, base, wl, sb, st, ok);
        if (!ok) return;
        t_resp = cyc;
        check({tag, "_i_resp"}, i_resp, !od);
        check({tag, "_d_resp"}, d_resp, od);
        check({tag, "_cmd_gap"}, {mem_read, mem_write}, 0);
        if (!wr) begin
            for (int k = 0; k < 4; k++) exp[64*k +: 64] = mem_model[base + 32'(8*k)];
            check({tag, "_rdata"}, od ? d_rdata : i_rdata, exp);
        end
        if (!keep) begin
            if (od) begin
                d_read = 0;
                d_write = 0;
            end else begin
                i_read = 0;
            end
        end
        @(negedge clk);
        check({tag, "_one_pulse"}, {i_resp, d_resp}, 0);
    endtask

    initial begin
        logic [255:0] wl;
        logic [255:0] ln;
        bit pi, pd, dw, od;
        int t0;

        // Reset state
        do_reset();
        check("reset_outs", {mem_read, mem_write, i_resp, d_resp, mem_addr, mem_burst_o}, 0);
        check("reset_rdata", i_rdata | d_rdata, 0);

        // 1: lone icache read
        mem_model[32'h1220] = 64'h1111_1111_1111_1111;
        mem_model[32'h1228] = 64'h2222_2222_2222_2222;
        mem_model[32'h1230] = 64'h3333_3333_3333_3333;
        mem_model[32'h1238] = 64'h4444_4444_4444_4444;
        i_read = 1; i_addr = 32'h0000_1234;
        od = pick_d(1, 0);
        serve("t1", 0, 32'h1220, 0, 4, 0, pi);
        check("t1_i_resp", i_resp, 1);
        check("t1_d_resp", d_resp, 0);
        ln = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        check("t1_rdata", i_rdata, ln);
        i_read = 0;
        @(negedge clk);
        check("t1_one_pulse", {i_resp, d_resp}, 0);

        // 2: dcache writeback, stalled before beat 2
        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        d_write = 1; d_addr = 32'h8000_0040; d_wdata = wl;
        od = pick_d(0, 1);
        run_one("t2", od, 1, 32'h8000_0040, wl, 2, 3, 0);

        // 3: both requesting from reset, held across four transactions
        do_reset();
        i_read = 1; i_addr = 32'h0000_0100;
        d_read = 1; d_addr = 32'h0000_0200;
        for (int n = 0; n < 4; n++) begin
            od = pick_d(1, 1);
            check("t3_order", od, n % 2);
            run_one("t3", od, 0, od ? 32'h200 : 32'h100, 0, 4, 0, 1);
        end
        i_read = 0; d_read = 0;
        @(negedge clk);

        // 4: ten-cycle stall between beats 1 and 2
        i_read = 1; i_addr = 32'h0000_3010;
        t0 = cyc;
        od = pick_d(1, 0);
        run_one("t4", od, 0, 32'h3000, 0, 2, 10, 0);
        check("t4_latency", t_resp - t0 + 1, 10 + 4 + 2);

        // 5: reset after beat 2 of a dcache read
        d_read = 1; d_addr = 32'h0000_5000;
        begin
            int n = 0;
            while (!mem_read && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("t5_cmd", mem_read, 1);
        end
        for (int k = 0; k < 2; k++) begin
            mem_resp = 1;
            mem_burst_i = rd_word(32'h5000 + 32'(8*k));
            @(negedge clk);
        end
        mem_resp = 0;
        rst = 1; d_read = 0;
        @(negedge clk);
        rst = 0;
        last_d_m = 1'b1;
        check("t5_outs", {mem_read, mem_write, i_resp, d_resp, mem_addr, mem_burst_o}, 0);
        check("t5_rdata", i_rdata | d_rdata, 0);
        i_read = 1; i_addr = 32'h0000_6008;
        od = pick_d(1, 0);
        run_one("t5", od, 0, 32'h6000, 0, 4, 0, 0);

        // 6: spurious strobes in IDLE, then read+write together
        mem_resp = 1;
        repeat (3) @(negedge clk);
        mem_resp = 0;
        check("t6_idle_cmd", {mem_read, mem_write}, 0);
        check("t6_idle_resp", {i_resp, d_resp}, 0);
        wl = rand_line();
        d_read = 1; d_write = 1; d_addr = 32'h0000_7000; d_wdata = wl;
        od = pick_d(0, 1);
        run_one("t6", od, 1, 32'h7000, wl, 4, 0, 0);

        // Randomized traffic
        pi = 0; pd = 0; dw = 0;
        for (int n = 0; n < 24; n++) begin
            if (!pi && ($urandom_range(0, 1) == 1)) begin
                pi = 1;
                i_addr = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 5)
                         | 32'($urandom_range(0, 31));
            end
            if (!pd && ($urandom_range(0, 1) == 1)) begin
                pd = 1;
                dw = 1'($urandom_range(0, 1));
                d_addr = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 5)
                         | 32'($urandom_range(0, 31));
                d_wdata = rand_line();
            end
            if (!pi && !pd) begin
                pi = 1;
                i_addr = 32'h4000_0100;
            end
            i_read = pi;
            d_read = pd && !dw;
            d_write = pd && dw;
            od = pick_d(pi, pd);
            run_one("rnd", od, od && dw, (od ? d_addr : i_addr) & ~32'h1F,
                    d_wdata, $urandom_range(0, 3), $urandom_range(0, 4), 0);
            if (od) pd = 0;
            else pi = 0;
        end
        i_read = 0; d_read = 0; d_write = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
